// File: rtl/adder_seq_ctrl_pkg.sv
// adder_seq_ctrl_pkg
// Shared definitions for the multi-cycle prefix-adder sequencer:
//   - datapath width and maximum prefix-stage count
//   - operand-size encodings and FSM state encoding
//   - size -> stage count, size -> lane mask, size -> result MSB lookups
package adder_seq_ctrl_pkg;

  localparam int LEN_DATA = 63;             // MSB index of the datapath
  localparam int NSTG     = 6;              // log2(LEN_DATA+1)

  typedef enum logic [1:0] {
    SIZE_8  = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_32 = 2'b10,
    SIZE_64 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Number of Sklansky stages needed to resolve all carries for a width.
  function automatic logic [2:0] size_to_nstg(input logic [1:0] size);
    case (size)
      SIZE_8:  return 3'd3;
      SIZE_16: return 3'd4;
      SIZE_32: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  // Active lanes [w-1:0] for a width.
  function automatic logic [LEN_DATA:0] size_to_mask(input logic [1:0] size);
    case (size)
      SIZE_8:  return 64'h0000_0000_0000_00FF;
      SIZE_16: return 64'h0000_0000_0000_FFFF;
      SIZE_32: return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Index of the top active bit (w-1).
  function automatic logic [5:0] size_to_msb(input logic [1:0] size);
    case (size)
      SIZE_8:  return 6'd7;
      SIZE_16: return 6'd15;
      SIZE_32: return 6'd31;
      default: return 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if
// Request/response bundle between ALU issue logic (master) and the adder
// sequencer (slave).
//   flush            master->slave  synchronous abort
//   in_valid/ready   request handshake; op_a, op_b, carry_in, sub, size
//   out_valid/ready  response handshake; result, carry_out, overflow, zero
interface adder_seq_ctrl_if;
  import adder_seq_ctrl_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [LEN_DATA:0] op_a;
  logic [LEN_DATA:0] op_b;
  logic              carry_in;
  logic              sub;
  logic [1:0]        size;
  logic              out_valid;
  logic              out_ready;
  logic [LEN_DATA:0] result;
  logic              carry_out;
  logic              overflow;
  logic              zero;

  modport master (
    output flush, in_valid, op_a, op_b, carry_in, sub, size, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  flush, in_valid, op_a, op_b, carry_in, sub, size, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/adder_seq_stage.sv
// adder_seq_stage
// One selectable Sklansky prefix stage (combinational).
//   i_g, i_p  : current generate / propagate vectors
//   i_mask    : active lanes; outputs are re-masked
//   i_stage   : stage index k (0..NSTG-1); larger values hold the vectors
//   o_g, o_p  : vectors after applying stage k
// Every bit carries a small gp cell per stage; the stage index picks which
// cell result is used.
module adder_seq_stage
  import adder_seq_ctrl_pkg::*;
(
  input  logic [LEN_DATA:0] i_g,
  input  logic [LEN_DATA:0] i_p,
  input  logic [LEN_DATA:0] i_mask,
  input  logic [2:0]        i_stage,
  output logic [LEN_DATA:0] o_g,
  output logic [LEN_DATA:0] o_p
);

  genvar gi, gk;
  generate
    for (gi = 0; gi <= LEN_DATA; gi++) begin : g_bit
      // One candidate per encodable stage index; unused indices hold.
      logic [7:0] w_gk;
      logic [7:0] w_pk;

      for (gk = 0; gk < 8; gk++) begin : g_stg
        if (gk < NSTG && ((gi >> gk) & 1) == 1) begin : g_cell
          // Source is the top bit of the lower half of this 2^(k+1) block.
          localparam int J = ((gi >> (gk + 1)) << (gk + 1)) + (1 << gk) - 1;
          assign w_gk[gk] = i_g[gi] | (i_p[gi] & i_g[J]);
          assign w_pk[gk] = i_p[gi] & i_p[J];
        end else begin : g_hold
          assign w_gk[gk] = i_g[gi];
          assign w_pk[gk] = i_p[gi];
        end
      end

      assign o_g[gi] = w_gk[i_stage] & i_mask[gi];
      assign o_p[gi] = w_pk[i_stage] & i_mask[gi];
    end
  endgenerate

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
// Multi-cycle sequencer for the parallel-prefix adder: one Sklansky stage per
// clock on a registered G/P vector; narrow sizes finish in fewer stages.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : adder_seq_ctrl_if.slave (request, response, flush)
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  adder_seq_ctrl_if.slave        bus
);

  state_e            r_state;
  state_e            w_state_next;
  logic [LEN_DATA:0] r_g, r_p, r_p0, r_mask;
  logic [LEN_DATA:0] r_result;
  logic              r_c0;
  logic [2:0]        r_nstg;
  logic [2:0]        r_stage;
  logic [5:0]        r_msb;
  logic              r_cout, r_ovf, r_zero;

  logic              w_accept;
  logic              w_advance;
  logic              w_last;
  logic [LEN_DATA:0] w_mask_in, w_bi, w_p0_in, w_g_in;
  logic              w_c0_in;
  logic [LEN_DATA:0] w_g_next, w_p_next;
  logic [LEN_DATA:0] w_c;
  logic [LEN_DATA:0] w_sum;
  logic [5:0]        w_msb_m1;

  // Request pre-processing: subtract inverts B and forces the carry-in.
  assign w_mask_in = size_to_mask(bus.size);
  assign w_bi      = bus.sub ? ~bus.op_b : bus.op_b;
  assign w_c0_in   = bus.sub ? 1'b1 : bus.carry_in;
  assign w_p0_in   = (bus.op_a ^ w_bi) & w_mask_in;
  // Carry-in is folded into G[0] so the prefix tree propagates it for free.
  assign w_g_in    = ((bus.op_a & w_bi) & w_mask_in)
                   | {{LEN_DATA{1'b0}}, w_p0_in[0] & w_c0_in};

  adder_seq_stage u_stage (
    .i_g     (r_g),
    .i_p     (r_p),
    .i_mask  (r_mask),
    .i_stage (r_stage),
    .o_g     (w_g_next),
    .o_p     (w_p_next)
  );

  // After the final stage G[i] is the carry out of bit i.
  assign w_c      = {w_g_next[LEN_DATA-1:0], r_c0};
  assign w_sum    = (r_p0 ^ w_c) & r_mask;
  assign w_msb_m1 = r_msb - 6'd1;
  assign w_last   = (r_stage == (r_nstg - 3'd1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.flush && bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_PREFIX;
        end
      end
      ST_PREFIX: begin
        if (bus.flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_advance = 1'b1;
          if (w_last) w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.flush || bus.out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g      <= '0;
      r_p      <= '0;
      r_p0     <= '0;
      r_mask   <= '0;
      r_c0     <= 1'b0;
      r_nstg   <= '0;
      r_stage  <= '0;
      r_msb    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_g     <= w_g_in;
      r_p     <= w_p0_in;
      r_p0    <= w_p0_in;
      r_mask  <= w_mask_in;
      r_c0    <= w_c0_in;
      r_nstg  <= size_to_nstg(bus.size);
      r_msb   <= size_to_msb(bus.size);
      r_stage <= '0;
    end else if (w_advance) begin
      r_g     <= w_g_next;
      r_p     <= w_p_next;
      r_stage <= r_stage + 3'd1;
      if (w_last) begin
        r_result <= w_sum;
        r_cout   <= w_g_next[r_msb];
        r_ovf    <= w_g_next[r_msb] ^ w_g_next[w_msb_m1];
        r_zero   <= (w_sum == '0);
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl
// Directed vector table plus hand-written sequences for backpressure, flush
// and asynchronous reset on adder_seq_ctrl.
module tb_adder_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  adder_seq_ctrl_if bus ();

  adder_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  size;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] exp_res;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+#1 with the DUT idle. Returns latency and outputs
  // captured while out_valid is high, then drains with out_ready for one edge.
  task automatic run_op(input vec_t v, output int lat, output logic busy,
                        output logic [63:0] res, output logic cout,
                        output logic ovf, output logic zro);
    bus.op_a      = v.a;
    bus.op_b      = v.b;
    bus.carry_in  = v.cin;
    bus.sub       = v.sub;
    bus.size      = v.size;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble inputs: they must not affect the in-flight op.
    bus.op_a     = ~v.a;
    bus.op_b     = ~v.b;
    bus.sub      = ~v.sub;
    bus.carry_in = ~v.cin;
    bus.size     = 2'b00;
    busy = bus.in_ready;
    lat  = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = bus.result;
    cout = bus.carry_out;
    ovf  = bus.overflow;
    zro  = bus.zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic        busy, cout, ovf, zro;
    logic [63:0] res;
    vec_t        v;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{"add64_wrap",   2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 6};
    vecs[1]  = '{"add8_ovf",     2'b00, 64'hDEAD_BEEF_1234_567F, 64'hFFFF_0000_0000_0001, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, 1'b0, 3};
    vecs[2]  = '{"sub32",        2'b10, 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 5};
    vecs[3]  = '{"sub16_eq",     2'b01, 64'h1234, 64'h1234, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 4};
    vecs[4]  = '{"add64_mix",    2'b11, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'h1234_5678_9ABC_DF01, 1'b0, 1'b0, 1'b0, 6};
    vecs[5]  = '{"add64_sovf",   2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 6};
    vecs[6]  = '{"sub64_neg",    2'b11, 64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 6};
    vecs[7]  = '{"sub8_ovf",     2'b00, 64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1, 1'b0, 3};
    vecs[8]  = '{"add8_wrap",    2'b00, 64'hFF, 64'h01, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 3};
    vecs[9]  = '{"sub32_hi",     2'b10, 64'hAAAA_0000_0000_0010, 64'h5555_0000_0000_0010, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 5};
    vecs[10] = '{"add16_cin",    2'b01, 64'h8000, 64'h8000, 1'b1, 1'b0, 64'h0001, 1'b1, 1'b1, 1'b0, 4};

    // Reset state
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.carry_in  = 1'b0;
    bus.sub       = 1'b0;
    bus.size      = 2'b00;
    #3;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    bus.result,         64'd0);
    chk("rst_flags",     {61'd0, bus.carry_out, bus.overflow, bus.zero}, 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], lat, busy, res, cout, ovf, zro);
      $display("vec %s lat=%0d res=%h cout=%0b ovf=%0b zero=%0b",
               vecs[i].name, lat, res, cout, ovf, zro);
      chk({vecs[i].name, "_lat"},  64'(lat),  64'(vecs[i].exp_lat));
      chk({vecs[i].name, "_busy"}, 64'(busy), 64'd0);
      chk({vecs[i].name, "_res"},  res,       vecs[i].exp_res);
      chk({vecs[i].name, "_cout"}, 64'(cout), 64'(vecs[i].exp_cout));
      chk({vecs[i].name, "_ovf"},  64'(ovf),  64'(vecs[i].exp_ovf));
      chk({vecs[i].name, "_zero"}, 64'(zro),  64'(vecs[i].exp_zero));
      chk({vecs[i].name, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
      chk({vecs[i].name, "_drain_held"},  bus.result,         vecs[i].exp_res);
    end

    // Async reset mid-PREFIX (previous result 0x0001 is nonzero)
    bus.op_a = 64'hFFFF_FFFF_FFFF_FFFF; bus.op_b = 64'h1; bus.sub = 1'b0;
    bus.carry_in = 1'b0; bus.size = 2'b11; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    $display("reset mid-op in_ready=%0b out_valid=%0b result=%h",
             bus.in_ready, bus.out_valid, bus.result);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_result",    bus.result,         64'd0);
    chk("arst_flags",     {61'd0, bus.carry_out, bus.overflow, bus.zero}, 64'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{"add16_post_rst", 2'b01, 64'h00FF, 64'hFF01, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 4};
    run_op(v, lat, busy, res, cout, ovf, zro);
    $display("vec %s lat=%0d res=%h cout=%0b", v.name, lat, res, cout);
    chk("post_rst_lat",  64'(lat),  64'd4);
    chk("post_rst_res",  res,       64'h0);
    chk("post_rst_cout", 64'(cout), 64'd1);
    chk("post_rst_zero", 64'(zro),  64'd1);

    // Backpressure: hold DONE for 4 cycles
    bus.op_a = 64'h10; bus.op_b = 64'h20; bus.sub = 1'b0; bus.carry_in = 1'b0;
    bus.size = 2'b00; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 64'(lat), 64'd3);
    for (int c = 0; c < 4; c++) begin
      $display("bp cycle %0d out_valid=%0b in_ready=%0b result=%h",
               c, bus.out_valid, bus.in_ready, bus.result);
      chk("bp_valid",    64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
      chk("bp_result",   bus.result,         64'h30);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_drain_ready", 64'(bus.in_ready),  64'd1);
    bus.op_a = 64'h3; bus.op_b = 64'h4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_next_accept", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("bp next op lat=%0d result=%h", lat, bus.result);
    chk("bp_next_res", bus.result, 64'h7);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Flush at PREFIX stage 2 of a 64b op
    bus.op_a = 64'h1; bus.op_b = 64'h1; bus.size = 2'b11; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready),  64'd1);
    chk("flush_valid",    64'(bus.out_valid), 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    $display("flush mid-op out_valid cycles=%0d", seen);
    chk("flush_no_result", 64'(seen), 64'd0);

    // flush + in_valid in IDLE: no accept
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_vs_valid_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid || !bus.in_ready) seen++;
      @(posedge clk); #1;
    end
    $display("flush+in_valid busy cycles=%0d", seen);
    chk("flush_vs_valid_idle", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
